// File: rtl/rr_arb.sv
// Registered round-robin arbiter over W requesters; the grant is held until acked.
// Optional build macro RR_ARB_LOCK_EN adds i_lock to hold the grant across multi-beat transfers.
module rr_arb #(
    parameter int W           = 4,
    parameter bit RR_FROM_LSB = 1'b1
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [W-1:0]         i_req,
    input  logic                 i_ack,
`ifdef RR_ARB_LOCK_EN
    input  logic                 i_lock,
`endif
    output logic [W-1:0]         o_gnt,
    output logic                 o_gnt_vld,
    output logic [$clog2(W)-1:0] o_gnt_idx
);

    localparam int            IW      = $clog2(W);
    localparam logic [IW-1:0] IDX_MAX = IW'(W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        GNT  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] w_ptr_adv;
    logic [IW-1:0] w_scan_ptr;
    logic [W-1:0]  r_gnt;
    logic [W-1:0]  w_gnt_nxt;
    logic [W-1:0]  w_win;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic [IW-1:0] w_win_idx;
    logic [IW-1:0] w_j;
    logic          w_win_vld;
    logic          w_hold_lock;

    // Next priority pointer after the current grant; wraps explicitly for non-power-of-two W.
    always_comb begin
        w_ptr_adv = r_idx;
        if (RR_FROM_LSB) begin
            w_ptr_adv = (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
        end else begin
            w_ptr_adv = (r_idx == '0) ? IDX_MAX : r_idx - IW'(1);
        end
    end

    // On an ack the scan starts from the advanced pointer so back-to-back grants need no bubble.
    assign w_scan_ptr = (r_state == GNT && i_ack) ? w_ptr_adv : r_ptr;

`ifdef RR_ARB_LOCK_EN
    assign w_hold_lock = i_lock & i_req[r_idx];
`else
    assign w_hold_lock = 1'b0;
`endif

    // Descending k loop: the smallest distance from the pointer overwrites last and wins.
    always_comb begin : p_scan
        int j;
        j         = 0;
        w_j       = '0;
        w_win     = '0;
        w_win_idx = '0;
        w_win_vld = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (RR_FROM_LSB) begin
                j = int'(w_scan_ptr) + k;
                if (j >= W) j = j - W;
            end else begin
                j = int'(w_scan_ptr) - k;
                if (j < 0) j = j + W;
            end
            w_j = IW'(j);
            if (i_req[w_j]) begin
                w_win_idx = w_j;
                w_win_vld = 1'b1;
            end
        end
        if (w_win_vld) w_win[w_win_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = GNT;
                    w_gnt_nxt   = w_win;
                    w_idx_nxt   = w_win_idx;
                end
            end
            GNT: begin
                if (i_ack && !w_hold_lock) begin
                    w_ptr_nxt = w_ptr_adv;
                    if (w_win_vld) begin
                        w_gnt_nxt = w_win;
                        w_idx_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_vld = |r_gnt;
    assign o_gnt_idx = r_idx;

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (arst) $onehot0(r_gnt));
    a_vld:    assert property (@(posedge clk) disable iff (arst) o_gnt_vld == (|r_gnt));
    a_idx:    assert property (@(posedge clk) disable iff (arst)
                  (r_gnt == (W'(1) << r_idx)) || (r_gnt == '0 && r_idx == '0));
    a_stable: assert property (@(posedge clk) disable iff (arst)
                  (o_gnt_vld && !i_ack) |=> $stable(r_gnt));
`endif

endmodule

// File: doc/rr_arb.md
Name: rr_arb

Overview:
- Registered round-robin arbiter over W requesters.
- Generalises the fixed-priority one-hot selector: priority rotates after each accepted grant, giving starvation-free fairness.
- The grant is held stable until the downstream consumer accepts it.
- Sits in front of shared resources (response buses, shared pipes) wherever multiple agents contend.

Parameters:
- W, 4, number of requesters; legal range 2..64.
- RR_FROM_LSB, 1, scan direction from the pointer: 1 scans ascending index with wrap, 0 scans descending index with wrap.

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  asynchronous reset, active-high.
- i_req  input  W  request vector; bit i set means requester i wants the resource.
- i_ack  input  1  consumer accepts the current grant; meaningful only while o_gnt_vld=1.
- o_gnt  output  W  registered one-hot grant vector; all zeros when idle.
- o_gnt_vld  output  1  a grant is presented; equals |o_gnt.
- o_gnt_idx  output  $clog2(W)  binary index of the granted requester; 0 when idle.

Behaviour:
- Reset:
  - One clock; arst is asynchronous and active-high.
  - While arst=1: o_gnt=0, o_gnt_vld=0, o_gnt_idx=0, pointer ptr=0, state=IDLE.
  - Deassertion takes effect at the next clk edge.
- State: ptr, a register of $clog2(W) bits holding the highest-priority index. FSM has two states, IDLE and GNT.
- Winner selection (combinational): the first set bit of i_req found by scanning from ptr in the RR_FROM_LSB direction, wrapping modulo W. The result is one-hot; if i_req=0 there is no winner.
- IDLE:
  - If i_req!=0, register the winner into o_gnt/o_gnt_idx and go to GNT.
  - Request-to-grant latency is 1 cycle.
  - If i_req=0, stay in IDLE.
- GNT:
  - o_gnt and o_gnt_idx hold stable every cycle that i_ack=0, regardless of i_req changes. A requester dropping its request is a protocol violation; the grant is still held.
  - On i_ack=1:
    - ptr <= (o_gnt_idx+1) mod W when RR_FROM_LSB=1, or (o_gnt_idx-1) mod W when RR_FROM_LSB=0.
    - The next winner is computed in the same cycle using the updated pointer value (bypassed) and masked against the current i_req.
    - If a winner exists, it is registered and the FSM stays in GNT: back-to-back grants, no bubble.
    - If no winner exists, o_gnt <= 0 and the FSM goes to IDLE.
- Re-grant of the same requester: the sole requester i is re-granted back-to-back after an ack, because the scan wraps back to i.
- Pointer wrap: for ptr=W-1 with RR_FROM_LSB=1, the pointer advances to 0. Non-power-of-two W must wrap explicitly, never by overflow.
- i_ack while IDLE: ignored; no state change.
- Reset mid-grant: the grant is dropped immediately (asynchronously) and ptr returns to 0.
- Invariants to assert:
  - o_gnt is $onehot0.
  - o_gnt_vld == |o_gnt.
  - o_gnt_idx encodes o_gnt.
  - o_gnt is stable while o_gnt_vld & ~i_ack.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds input port i_lock (1 bit).
  - i_ack=1 with i_lock=1 marks a non-final beat of a multi-beat transfer.
  - ptr is not advanced and re-arbitration is suppressed.
  - If the granted requester's i_req bit is still set, o_gnt stays on the same requester. If not, behaviour is as if i_lock=0.
  - i_lock is ignored when i_ack=0 or when in IDLE.
- Undefined: the port is absent and every ack rotates priority as described above.

Test Plan:
- Reset priority: W=4, RR_FROM_LSB=1, reset, then i_req=4'b1111 held with i_ack=1 every cycle -> o_gnt_idx sequence 0,1,2,3,0, with the first grant appearing 1 cycle after the request and no idle cycles between grants.
- Stall: i_req=4'b0110, i_ack=0 for 5 cycles -> o_gnt=4'b0010 stable for all 5 cycles; on ack, the next cycle gives o_gnt=4'b0100.
- Drain and wrap: i_req=4'b1001 with ptr at 3 -> grant 3; after ack, grant 0; after ack with i_req=0 -> o_gnt=0 and IDLE on the following cycle.
- Sole requester: i_req=4'b0100, ack every cycle -> o_gnt=4'b0100 continuously; non-power-of-two case W=3 with i_req=3'b111 -> idx 0,1,2,0.
- Async reset: assert arst mid-grant (o_gnt=4'b1000) between clock edges -> o_gnt=0 immediately; after release with i_req=4'b1111, the first grant is idx 0.
- RR_ARB_LOCK_EN: i_req=4'b0011, grant 0, then three acks with i_lock=1 followed by an ack with i_lock=0 -> idx 0 held for 4 beats, then idx 1.
